// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and queue entry type for the fetch front end
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetch entries with flush and registered head
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  fetch_entry_t             push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output fetch_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // A push into a full queue is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL) || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with redirect/flush
// Optional decode-stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_instr_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt_o
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

   logic [XLEN-1:0] req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d, target_pc;
   logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, count;
   logic            credit_ok, req_fire, push, pop, unused_pc_bits;
   fetch_entry_t    push_entry, head;

   assign target_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};
   assign unused_pc_bits = ^redirect_pc_i[1:0];

   // Credit counts in-flight plus buffered fetches; a same-cycle pop is ignored.
   assign credit_ok        = ({1'b0, outst_q} + {1'b0, count}) < LIMIT;
   assign imem_req_valid_o = rst_i && start_i && credit_ok;
   assign imem_req_addr_o  = req_pc_q;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;
   assign pop              = instr_valid_o && instr_ready_i && !redirect_i;

   always_comb begin
      req_pc_d   = req_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      push       = 1'b0;
      push_entry = '{pc: rsp_pc_q, instr: imem_rsp_instr_i};
      outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
      if (redirect_i) begin
         req_pc_d = target_pc;
         rsp_pc_d = target_pc;
         drop_d   = outst_d;
      end else begin
         if (req_fire) begin
            req_pc_d = req_pc_q + PC_STEP;
         end
         if (imem_rsp_valid_i) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               push     = 1'b1;
               rsp_pc_d = rsp_pc_q + PC_STEP;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         req_pc_q <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         req_pc_q <= req_pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_i),
      .head_o      (head),
      .count_o     (count)
   );

   assign instr_valid_o = (count != '0);
   assign instr_o       = head.instr;
   assign pc_o          = head.pc;

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
      end else if (instr_valid_o && !instr_ready_i && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit; stall counter checked under FETCH_STALL_CNT_EN
module tb_fetch_unit;
   logic        clk_i = 1'b0;
   logic        rst_i, start_i, imem_req_ready_i, imem_rsp_valid_i;
   logic        instr_ready_i, redirect_i;
   logic [31:0] imem_rsp_instr_i, redirect_pc_i;
   logic        imem_req_valid_o, instr_valid_o;
   logic [31:0] imem_req_addr_o, instr_o, pc_o;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .start_i          (start_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_instr_i (imem_rsp_instr_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_o          (instr_o),
      .pc_o             (pc_o),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cnt_o      (stall_cnt_o)
`endif
   );

   typedef struct {
      logic        irdy;
      logic        exp_rv;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t        vecs [15];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] pq [$];
   logic [31:0] issued [$];
   logic [31:0] deliv_pc [$];
   logic [31:0] deliv_instr [$];
   logic        rsp_hold;
   logic        s_rv, s_iv;
   logic [31:0] s_addr, s_pc, s_instr;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One clock: memory answers in order from earlier-accepted requests unless held.
   task automatic tick();
      logic fire, popped;
      if (!rsp_hold && pq.size() > 0) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_instr_i = instr_of(pq[0]);
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_instr_i = 32'h0;
      end
      #1;
      s_rv    = imem_req_valid_o;
      s_addr  = imem_req_addr_o;
      s_iv    = instr_valid_o;
      s_pc    = pc_o;
      s_instr = instr_o;
      fire    = s_rv && imem_req_ready_i;
      popped  = s_iv && instr_ready_i && !redirect_i;
      @(posedge clk_i);
      if (imem_rsp_valid_i) pq.delete(0);
      if (fire) begin
         pq.push_back(s_addr);
         issued.push_back(s_addr);
      end
      if (popped) begin
         deliv_pc.push_back(s_pc);
         deliv_instr.push_back(s_instr);
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i            = 1'b0;
      start_i          = 1'b0;
      redirect_i       = 1'b0;
      redirect_pc_i    = 32'h0;
      instr_ready_i    = 1'b0;
      imem_req_ready_i = 1'b1;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_instr_i = 32'h0;
      rsp_hold         = 1'b0;
      pq.delete();
      issued.delete();
      deliv_pc.delete();
      deliv_instr.delete();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic wait_deliv(input string name, input int n);
      for (int i = 0; i < 20 && deliv_pc.size() < n; i++) tick();
      chk({name, "_timeout"}, 32'(deliv_pc.size() >= n), 32'd1);
   endtask

   initial begin
      logic        ok;
      logic [31:0] wexp [3];

      vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      vecs[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
      vecs[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
      vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
      vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
      vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
      vecs[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
      vecs[11] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
      vecs[12] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
      vecs[13] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
      vecs[14] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

      // Reset values, with start_i high to show requests stay off.
      rst_i = 1'b0; start_i = 1'b1; imem_req_ready_i = 1'b1; instr_ready_i = 1'b0;
      redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_rsp_valid_i = 1'b0; imem_rsp_instr_i = 32'h0;
      rsp_hold = 1'b0;
      #2;
      chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
`ifdef FETCH_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt_o, 32'h0);
`endif
      do_reset();

      // Streaming, then a 4-cycle decode stall and resume.
      start_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         instr_ready_i = vecs[i].irdy;
         tick();
         total++;
         ok = (s_rv === vecs[i].exp_rv) && (s_iv === vecs[i].exp_iv)
              && (!vecs[i].exp_rv || (s_addr === vecs[i].exp_addr))
              && (!vecs[i].exp_iv || ((s_pc === vecs[i].exp_pc) && (s_instr === instr_of(vecs[i].exp_pc))));
         if (!ok) begin
            bad++;
            $display("FAIL vec%0d rv=%b/%b addr=%h/%h iv=%b/%b pc=%h/%h instr=%h/%h", i,
                     s_rv, vecs[i].exp_rv, s_addr, vecs[i].exp_addr, s_iv, vecs[i].exp_iv,
                     s_pc, vecs[i].exp_pc, s_instr, instr_of(vecs[i].exp_pc));
         end
      end
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cnt", stall_cnt_o, 32'd4);
`endif

      // Redirect with two fetches outstanding and a non-empty queue.
      do_reset();
      start_i = 1'b1;
      tick();
      tick();
      rsp_hold = 1'b1;
      tick();
      start_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
      tick();
      chk("redir_pre_iv", 32'(s_iv), 32'd1);
      chk("redir_pre_pc", s_pc, 32'h0);
      redirect_i = 1'b0; start_i = 1'b1; rsp_hold = 1'b0; instr_ready_i = 1'b1;
      tick();
      chk("redir_flushed_iv", 32'(s_iv), 32'd0);
      chk("redir_req_valid", 32'(s_rv), 32'd1);
      chk("redir_req_addr", s_addr, 32'h100);
      wait_deliv("redir", 2);
      chk("redir_pc0", deliv_pc.size() > 0 ? deliv_pc[0] : 32'hDEAD_BEEF, 32'h100);
      chk("redir_instr0", deliv_instr.size() > 0 ? deliv_instr[0] : 32'hDEAD_BEEF, instr_of(32'h100));
      chk("redir_pc1", deliv_pc.size() > 1 ? deliv_pc[1] : 32'hDEAD_BEEF, 32'h104);

      // Redirect coinciding with a request handshake and a response arrival.
      do_reset();
      start_i = 1'b1; instr_ready_i = 1'b1;
      tick();
      redirect_i = 1'b1; redirect_pc_i = 32'h203;
      tick();
      chk("same_req_fire", 32'(s_rv), 32'd1);
      redirect_i = 1'b0;
      tick();
      chk("same_req_addr", s_addr, 32'h200);
      wait_deliv("same", 1);
      chk("same_pc0", deliv_pc.size() > 0 ? deliv_pc[0] : 32'hDEAD_BEEF, 32'h200);
      chk("same_instr0", deliv_instr.size() > 0 ? deliv_instr[0] : 32'hDEAD_BEEF, instr_of(32'h200));

      // PC wrap at the top of the address space.
      do_reset();
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFB;
      tick();
      redirect_i = 1'b0; start_i = 1'b1; instr_ready_i = 1'b1;
      repeat (8) tick();
      wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wrap_addr%0d", i), i < issued.size() ? issued[i] : 32'hDEAD_BEEF, wexp[i]);
         chk($sformatf("wrap_pc%0d", i), i < deliv_pc.size() ? deliv_pc[i] : 32'hDEAD_BEEF, wexp[i]);
      end

      // Asynchronous reset with buffered entries and two fetches outstanding.
      do_reset();
      start_i = 1'b1;
      tick();
      tick();
      tick();
      rsp_hold = 1'b1;
      tick();
      tick();
      chk("midrst_credit_full", 32'(s_rv), 32'd0);
      chk("midrst_pre_iv", 32'(s_iv), 32'd1);
      #2;
      rst_i = 1'b0;
      #1;
      chk("midrst_iv", 32'(instr_valid_o), 32'd0);
      chk("midrst_pc", pc_o, 32'h0);
      chk("midrst_req_valid", 32'(imem_req_valid_o), 32'd0);
      do_reset();
      start_i = 1'b1; instr_ready_i = 1'b1;
      tick();
      chk("midrst_first_addr", s_addr, 32'h0);
      wait_deliv("midrst", 1);
      chk("midrst_pc0", deliv_pc.size() > 0 ? deliv_pc[0] : 32'hDEAD_BEEF, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
